// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and pixel-stream generator with pixel-rate divider and registered outputs.
// Define VGA_TIMING_PATTERN_EN to build in the frame-latched test-pattern generator.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CLK_DIV    = 2,
    parameter int COLOR_W    = 6,
    parameter int CNT_W      = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         pattern_mode,
    input  logic [COLOR_W-1:0] pix_rgb_i,
    output logic               pix_req,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COLOR_W-1:0] rgb,
    output logic               frame_start,
    output logic               line_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic             HS_ON    = (H_SYNC_POL != 0);
    localparam logic             VS_ON    = (V_SYNC_POL != 0);

    logic [DIV_W-1:0]   div;
    logic [CNT_W-1:0]   h;
    logic [CNT_W-1:0]   v;
    logic               pe;
    logic               visible;
    logic               origin;
    logic               hs_act;
    logic               vs_act;
    logic [COLOR_W-1:0] colour;

    assign pe      = en && (div == '0);
    assign visible = (h < H_VIS_C) && (v < V_VIS_C);
    assign origin  = (h == '0) && (v == '0);
    assign hs_act  = (h >= HS_START) && (h < HS_END);
    assign vs_act  = (v >= VS_START) && (v < VS_END);
    assign pix_req = pe && visible;
    assign x       = h;
    assign y       = v;

    // Pixel-rate divider: pe fires on the first clk after en rises, then every CLK_DIV clks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (!en || div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (!en) begin
            h <= '0;
            v <= '0;
        end else if (pe) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

`ifdef VGA_TIMING_PATTERN_EN
    localparam int CH_W  = COLOR_W / 3;
    localparam int BAR_W = (H_VISIBLE >= 8) ? H_VISIBLE / 8 : 1;

    logic [1:0] mode_q;
    logic [1:0] mode_eff;

    function automatic logic [COLOR_W-1:0] pattern_pixel(
        input logic [1:0]         mode,
        input logic [CNT_W-1:0]   hc,
        input logic [5:0]         vl,
        input logic [COLOR_W-1:0] pix
    );
        logic [2:0] bar;
        bar           = 3'(hc / CNT_W'(BAR_W));
        pattern_pixel = '0;
        case (mode)
            2'd0: pattern_pixel = pix;
            2'd1: pattern_pixel = '1;
            2'd2: if (hc[5:0] == 6'd0 || vl == 6'd0)
                      pattern_pixel = {{CH_W{1'b0}}, {CH_W{1'b1}}, {CH_W{1'b0}}};
            default: pattern_pixel = {{CH_W{bar[2]}}, {CH_W{bar[1]}}, {CH_W{bar[0]}}};
        endcase
        return pattern_pixel;
    endfunction

    // A new mode is honoured from pixel (0,0) onward, so a whole frame always uses one mode
    assign mode_eff = (pe && origin) ? pattern_mode : mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 2'd0;
        end else if (pe && origin) begin
            mode_q <= pattern_mode;
        end
    end

    assign colour = pattern_pixel(mode_eff, h, v[5:0], pix_rgb_i);
`else
    logic unused_pattern_mode;
    assign unused_pattern_mode = ^pattern_mode;
    assign colour              = pix_rgb_i;
`endif

    // Output stage: everything below is one pixel behind h/v
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de          <= 1'b0;
            rgb         <= '0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            de          <= 1'b0;
            rgb         <= '0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pe) begin
            de          <= visible;
            rgb         <= visible ? colour : '0;
            hsync       <= hs_act ? HS_ON : ~HS_ON;
            vsync       <= vs_act ? VS_ON : ~VS_ON;
            line_start  <= visible && !de;
            frame_start <= visible && !de && origin;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
